// File: rtl/piso_pkg.sv
// Shared constants and elaboration helpers for the piso_tx serial transmitter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package piso_pkg;

    // FSM state encodings.
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    // Bit counter width: max(1, clog2(width)).
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

    // Legal parameter ranges for the transmitter.
    function automatic bit params_ok(input int width, input int gap_cycles);
        return (width >= 2) && (width <= 32) && (gap_cycles >= 0) && (gap_cycles <= 255);
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo counter 0..MAX with synchronous clear, enable and terminal-count flag.
// Latency: count updates one cycle after enable; tc is combinational from count.
// Backpressure: none; holds its value while enable is low.
module mod_counter #(
    parameter int W   = 4,
    parameter int MAX = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    assign tc = (cnt == W'(MAX));

    // Count up while enabled, wrapping to zero after the terminal value.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: one word per load handshake, one bit per clock.
// Latency: first bit on so the cycle after the accept edge; frame_done the cycle after the last bit.
// Backpressure: load_ready is high only in IDLE; load_valid is ignored while shifting or in the gap.
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int MSB_FIRST  = 0,
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pdata_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             so,
    output logic             so_valid,
    output logic             so_last,
    output logic             busy,
    output logic             frame_done
);

    localparam int CW      = cnt_width(WIDTH);
    localparam int GAP_MAX = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;

    if (!params_ok(WIDTH, GAP_CYCLES)) begin : g_param_err
        $error("piso_tx: WIDTH must be 2..32 and GAP_CYCLES 0..255");
    end

    logic [1:0]       state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    bit_cnt;
    logic             bit_tc;
    logic [7:0]       gap_cnt_unused;
    logic             gap_tc;
    logic             accept;
    logic             frame_end;

    assign accept     = (state == IDLE) && load_valid;
    assign frame_end  = (state == SHIFT) && bit_tc;
    assign load_ready = (state == IDLE);
    assign busy       = (state != IDLE);

    // Bit position within the frame: cleared on accept, advances every SHIFT cycle.
    mod_counter #(
        .W   (CW),
        .MAX (WIDTH - 1)
    ) u_bit_cnt (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .en  (state == SHIFT),
        .cnt (bit_cnt),
        .tc  (bit_tc)
    );

    // Idle spacing after a frame: cleared at frame end, advances every GAP cycle.
    mod_counter #(
        .W   (8),
        .MAX (GAP_MAX)
    ) u_gap_cnt (
        .clk (clk),
        .rst (rst),
        .clr (frame_end),
        .en  (state == GAP),
        .cnt (gap_cnt_unused),
        .tc  (gap_tc)
    );

    // FSM, shift register and registered serial outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sreg       <= '0;
            so         <= 1'b0;
            so_valid   <= 1'b0;
            so_last    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        sreg     <= pdata_in;
                        so       <= (MSB_FIRST != 0) ? pdata_in[WIDTH-1] : pdata_in[0];
                        so_valid <= 1'b1;
                        so_last  <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_tc) begin
                        so         <= 1'b0;
                        so_valid   <= 1'b0;
                        so_last    <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= (GAP_CYCLES == 0) ? IDLE : GAP;
                    end else begin
                        if (MSB_FIRST != 0) begin
                            sreg <= {sreg[WIDTH-2:0], 1'b0};
                            so   <= sreg[WIDTH-2];
                        end else begin
                            sreg <= {1'b0, sreg[WIDTH-1:1]};
                            so   <= sreg[1];
                        end
                        // The bit being loaded now is the final one when the count is one short.
                        so_last <= (bit_cnt == CW'(WIDTH - 2));
                    end
                end
                GAP: begin
                    if (gap_tc) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: cycle table on a 4-bit LSB-first instance,
// plus hand-written sequences for MSB-first, inter-frame gap and an 8-bit width.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_piso_tx;

    logic clk;
    logic rst;

    // 4-bit, LSB first, no gap
    logic [3:0] a_pd;
    logic a_lv, a_lr, a_so, a_sv, a_sl, a_busy, a_fd;
    // 4-bit, MSB first, no gap
    logic [3:0] m_pd;
    logic m_lv, m_lr, m_so, m_sv, m_sl, m_busy, m_fd;
    // 4-bit, LSB first, 2 gap cycles
    logic [3:0] g_pd;
    logic g_lv, g_lr, g_so, g_sv, g_sl, g_busy, g_fd;
    // 8-bit, LSB first, no gap
    logic [7:0] w_pd;
    logic w_lv, w_lr, w_so, w_sv, w_sl, w_busy, w_fd;

    int tests;
    int fails;

    piso_tx #(.WIDTH(4), .MSB_FIRST(0), .GAP_CYCLES(0)) u_lsb (
        .clk(clk), .rst(rst), .pdata_in(a_pd), .load_valid(a_lv), .load_ready(a_lr),
        .so(a_so), .so_valid(a_sv), .so_last(a_sl), .busy(a_busy), .frame_done(a_fd));

    piso_tx #(.WIDTH(4), .MSB_FIRST(1), .GAP_CYCLES(0)) u_msb (
        .clk(clk), .rst(rst), .pdata_in(m_pd), .load_valid(m_lv), .load_ready(m_lr),
        .so(m_so), .so_valid(m_sv), .so_last(m_sl), .busy(m_busy), .frame_done(m_fd));

    piso_tx #(.WIDTH(4), .MSB_FIRST(0), .GAP_CYCLES(2)) u_gap (
        .clk(clk), .rst(rst), .pdata_in(g_pd), .load_valid(g_lv), .load_ready(g_lr),
        .so(g_so), .so_valid(g_sv), .so_last(g_sl), .busy(g_busy), .frame_done(g_fd));

    piso_tx #(.WIDTH(8), .MSB_FIRST(0), .GAP_CYCLES(0)) u_w8 (
        .clk(clk), .rst(rst), .pdata_in(w_pd), .load_valid(w_lv), .load_ready(w_lr),
        .so(w_so), .so_valid(w_sv), .so_last(w_sl), .busy(w_busy), .frame_done(w_fd));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row per cycle: outputs expected this cycle, inputs for the coming edge.
    // exp = {so, so_valid, so_last, frame_done, load_ready, busy}
    typedef struct {
        logic       r;
        logic       lv;
        logic [3:0] pd;
        logic [5:0] exp;
    } vec_t;

    function automatic vec_t v(input logic r, input logic lv, input logic [3:0] pd, input logic [5:0] exp);
        vec_t t;
        t.r = r; t.lv = lv; t.pd = pd; t.exp = exp;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
        end
    endtask

    localparam logic [5:0] O_IDLE = 6'b000010;
    localparam logic [5:0] O_B1   = 6'b110001;
    localparam logic [5:0] O_B0   = 6'b010001;
    localparam logic [5:0] O_L1   = 6'b111001;
    localparam logic [5:0] O_L0   = 6'b011001;
    localparam logic [5:0] O_DONE = 6'b000110;

    initial begin
        vec_t tbl[$];
        logic [3:0] mword;
        logic [3:0] gwords[2];
        logic [7:0] wwords[2];

        tests = 0;
        fails = 0;
        rst  = 1'b1;
        a_lv = 1'b0; a_pd = '0;
        m_lv = 1'b0; m_pd = '0;
        g_lv = 1'b0; g_pd = '0;
        w_lv = 1'b0; w_pd = '0;

        // Basic frame 4'b1011 -> 1,1,0,1
        tbl.push_back(v(0, 1, 4'hB, O_IDLE));
        tbl.push_back(v(0, 0, 4'h0, O_B1));
        tbl.push_back(v(0, 0, 4'h0, O_B1));
        tbl.push_back(v(0, 0, 4'h0, O_B0));
        tbl.push_back(v(0, 0, 4'h0, O_L1));
        tbl.push_back(v(0, 0, 4'h0, O_DONE));
        tbl.push_back(v(0, 0, 4'h0, O_IDLE));
        // load_valid held through a frame of 4'hF while pdata_in drops to 0; then 4'h5
        tbl.push_back(v(0, 1, 4'hF, O_IDLE));
        tbl.push_back(v(0, 1, 4'h0, O_B1));
        tbl.push_back(v(0, 1, 4'h0, O_B1));
        tbl.push_back(v(0, 1, 4'h0, O_B1));
        tbl.push_back(v(0, 1, 4'h0, O_L1));
        tbl.push_back(v(0, 1, 4'h5, O_DONE));
        tbl.push_back(v(0, 0, 4'h0, O_B1));
        tbl.push_back(v(0, 0, 4'h0, O_B0));
        tbl.push_back(v(0, 0, 4'h0, O_B1));
        tbl.push_back(v(0, 0, 4'h0, O_L0));
        tbl.push_back(v(0, 0, 4'h0, O_DONE));
        // Reset during bit 2 of 4'b0110
        tbl.push_back(v(0, 1, 4'h6, O_IDLE));
        tbl.push_back(v(0, 0, 4'h0, O_B0));
        tbl.push_back(v(0, 0, 4'h0, O_B1));
        tbl.push_back(v(1, 0, 4'h0, O_B1));
        tbl.push_back(v(0, 0, 4'h0, O_IDLE));
        tbl.push_back(v(0, 0, 4'h0, O_IDLE));
        // Reset wins over a simultaneous load
        tbl.push_back(v(1, 1, 4'hF, O_IDLE));
        tbl.push_back(v(0, 0, 4'h0, O_IDLE));
        tbl.push_back(v(0, 0, 4'h0, O_IDLE));

        repeat (2) @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            check($sformatf("lsb_row%0d {so,vld,last,done,rdy,busy}", i),
                  32'({a_so, a_sv, a_sl, a_fd, a_lr, a_busy}), 32'(tbl[i].exp));
            rst  = tbl[i].r;
            a_lv = tbl[i].lv;
            a_pd = tbl[i].pd;
            @(negedge clk);
        end
        rst = 1'b0; a_lv = 1'b0;

        // MSB first: 4'b1011 -> 1,0,1,1
        mword = 4'b1011;
        check("msb_idle_ready", 32'(m_lr), 32'd1);
        m_lv = 1'b1; m_pd = mword;
        @(negedge clk);
        m_lv = 1'b0; m_pd = 4'h0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("msb_bit%0d {so,vld,last}", k),
                  32'({m_so, m_sv, m_sl}), 32'({mword[3-k], 1'b1, (k == 3)}));
            @(negedge clk);
        end
        check("msb_end {so,vld,done,rdy}", 32'({m_so, m_sv, m_fd, m_lr}), 32'b0011);

        // Gap of 2 with back-to-back producer: 4'hA then 4'h5
        gwords[0] = 4'hA; gwords[1] = 4'h5;
        begin
            int idx, nb, nframes, fd_cyc, f;
            bit pend;
            int acc_cyc[2];
            logic [3:0] rec;
            logic [3:0] got[2];
            logic lr_hist[32];
            idx = 0; nb = 0; nframes = 0; fd_cyc = -1; pend = 0; rec = '0;
            acc_cyc[0] = -100; acc_cyc[1] = -100; got[0] = '0; got[1] = '0;
            for (int c = 0; c < 32; c++) lr_hist[c] = 1'bx;
            for (int c = 0; c < 25; c++) begin
                if (c > 0) @(negedge clk);
                if (pend) begin pend = 0; idx++; end
                lr_hist[c] = g_lr;
                if (g_sv) begin
                    if (nb < 4) rec[nb] = g_so;
                    nb++;
                end
                if (g_fd) begin
                    if (nframes < 2) got[nframes] = rec;
                    if (fd_cyc < 0) fd_cyc = c;
                    nframes++;
                    nb = 0;
                    rec = '0;
                end
                g_lv = (idx < 2);
                g_pd = (idx < 2) ? gwords[idx] : 4'h0;
                if (g_lv && g_lr) begin pend = 1; acc_cyc[idx] = c; end
            end
            g_lv = 1'b0;
            check("gap_frames", 32'(nframes), 32'd2);
            check("gap_word0", 32'(got[0]), 32'hA);
            check("gap_word1", 32'(got[1]), 32'h5);
            check("gap_first_done_cycle", 32'(fd_cyc), 32'd5);
            f = (fd_cyc < 0 || fd_cyc > 29) ? 0 : fd_cyc;
            check("gap_rdy_done+0", 32'(lr_hist[f]), 32'd0);
            check("gap_rdy_done+1", 32'(lr_hist[f+1]), 32'd0);
            check("gap_rdy_done+2", 32'(lr_hist[f+2]), 32'd1);
            check("gap_accept_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd7);
        end

        // 8-bit: 8'h81 then 8'h3C, checks bit count, last marker and counter wrap
        wwords[0] = 8'h81; wwords[1] = 8'h3C;
        @(negedge clk);
        begin
            int idx, nb, nframes, lc, lp, viol;
            bit pend;
            logic [7:0] rec;
            logic [7:0] got[2];
            int vc[2], lcs[2], lps[2];
            idx = 0; nb = 0; nframes = 0; lc = 0; lp = -1; viol = 0; pend = 0; rec = '0;
            for (int j = 0; j < 2; j++) begin got[j] = '0; vc[j] = 0; lcs[j] = 0; lps[j] = -1; end
            for (int c = 0; c < 30; c++) begin
                if (c > 0) @(negedge clk);
                if (pend) begin pend = 0; idx++; end
                if (!w_sv && w_so) viol++;
                if (w_sv) begin
                    if (nb < 8) rec[nb] = w_so;
                    if (w_sl) begin lc++; lp = nb; end
                    nb++;
                end
                if (w_fd) begin
                    if (nframes < 2) begin
                        got[nframes] = rec; vc[nframes] = nb;
                        lcs[nframes] = lc; lps[nframes] = lp;
                    end
                    nframes++;
                    nb = 0; lc = 0; lp = -1; rec = '0;
                end
                w_lv = (idx < 2);
                w_pd = (idx < 2) ? wwords[idx] : 8'h00;
                if (w_lv && w_lr) pend = 1;
            end
            w_lv = 1'b0;
            check("w8_frames", 32'(nframes), 32'd2);
            check("w8_word0", 32'(got[0]), 32'h81);
            check("w8_first_bit", 32'(got[0][0]), 32'd1);
            check("w8_last_bit", 32'(got[0][7]), 32'd1);
            check("w8_valid_cycles0", 32'(vc[0]), 32'd8);
            check("w8_last_count0", 32'(lcs[0]), 32'd1);
            check("w8_last_pos0", 32'(lps[0]), 32'd7);
            check("w8_word1_after_wrap", 32'(got[1]), 32'h3C);
            check("w8_valid_cycles1", 32'(vc[1]), 32'd8);
            check("w8_last_pos1", 32'(lps[1]), 32'd7);
            check("w8_so_zero_when_idle", 32'(viol), 32'd0);
            check("w8_idle_after {busy,rdy,vld}", 32'({w_busy, w_lr, w_sv}), 32'b010);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
